// File: rtl/video_in_axis_packer.sv
// Free-running 24-bit pixel stream to 32-bit AXI4-Stream with frame resync.
// Optional ERROR_CNT_EN macro builds the saturating overflow event counter.
module video_in_axis_packer #(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [7:0]  ALPHA      = 8'h00
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic                          cfg_enable,
    input  logic                          vid_valid,
    input  logic [23:0]                   vid_data,
    input  logic                          vid_sof,
    input  logic                          vid_eol,
    output logic                          OUTPUT_STREAM_TVALID,
    input  logic                          OUTPUT_STREAM_TREADY,
    output logic [31:0]                   OUTPUT_STREAM_TDATA,
    output logic [3:0]                    OUTPUT_STREAM_TKEEP,
    output logic [3:0]                    OUTPUT_STREAM_TSTRB,
    output logic                          OUTPUT_STREAM_TUSER,
    output logic                          OUTPUT_STREAM_TLAST,
    output logic                          OUTPUT_STREAM_TID,
    output logic                          OUTPUT_STREAM_TDEST,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          in_frame,
    output logic [15:0]                   ovf_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        WAIT_SOF,
        ACTIVE,
        DROP
    } state_t;

    state_t         state_q, state_d;
    logic [25:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [LW-1:0]  level_q;
    logic           full, empty;
    logic           wr_en, rd_en, ovf_d, ovf_q;
    logic           sof_ok;
    logic [25:0]    head;

    assign full   = (level_q == LW'(FIFO_DEPTH));
    assign empty  = (level_q == '0);
    assign rd_en  = !empty && OUTPUT_STREAM_TREADY;
    assign sof_ok = vid_valid && vid_sof && !full;

    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        ovf_d   = 1'b0;
        if (!cfg_enable) begin
            state_d = WAIT_SOF;
        end else begin
            unique case (state_q)
                WAIT_SOF, DROP: begin
                    if (sof_ok) begin
                        wr_en   = 1'b1;
                        state_d = ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (vid_valid) begin
                        if (full) begin
                            ovf_d   = 1'b1;
                            state_d = DROP;
                        end else begin
                            wr_en = 1'b1;
                        end
                    end
                end
                default: state_d = WAIT_SOF;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= WAIT_SOF;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ovf_q   <= ovf_d;
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage needs no reset; outputs are masked while the FIFO is empty.
    always_ff @(posedge aclk) begin
        if (wr_en) mem[wr_ptr] <= {vid_sof, vid_eol, vid_data};
    end

    assign head                 = mem[rd_ptr];
    assign OUTPUT_STREAM_TVALID = !empty;
    assign OUTPUT_STREAM_TDATA  = empty ? 32'h0 : {ALPHA, head[23:0]};
    assign OUTPUT_STREAM_TUSER  = !empty && head[25];
    assign OUTPUT_STREAM_TLAST  = !empty && head[24];
    assign OUTPUT_STREAM_TKEEP  = 4'hF;
    assign OUTPUT_STREAM_TSTRB  = 4'hF;
    assign OUTPUT_STREAM_TID    = 1'b0;
    assign OUTPUT_STREAM_TDEST  = 1'b0;
    assign fifo_level           = level_q;
    assign overflow             = ovf_q;
    assign in_frame             = (state_q == ACTIVE);

`ifdef ERROR_CNT_EN
    logic [15:0] ovf_cnt_q;

    always_ff @(posedge aclk) begin
        if (areset) begin
            ovf_cnt_q <= '0;
        end else if (ovf_d && ovf_cnt_q != 16'hFFFF) begin
            ovf_cnt_q <= ovf_cnt_q + 16'd1;
        end
    end

    assign ovf_count = ovf_cnt_q;
`else
    assign ovf_count = 16'h0000;
`endif

endmodule

// File: tb/tb_video_in_axis_packer.sv
// Randomised and directed bench for video_in_axis_packer against a queue model.
module tb_video_in_axis_packer;

    localparam int DEPTH = 16;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        cfg_enable = 1'b0;
    logic        vid_valid = 1'b0;
    logic [23:0] vid_data = '0;
    logic        vid_sof = 1'b0;
    logic        vid_eol = 1'b0;
    logic        tready = 1'b0;
    logic        tvalid, tuser, tlast, tid, tdest;
    logic [31:0] tdata;
    logic [3:0]  tkeep, tstrb;
    logic [4:0]  fifo_level;
    logic        overflow, in_frame;
    logic [15:0] ovf_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: pixels waiting for the sink, plus frame-lock mode.
    logic [25:0] q[$];
    int          mode = 0;
    logic        m_ovf = 1'b0;
    int          m_cnt = 0;

    always #5 aclk = ~aclk;

    video_in_axis_packer #(.FIFO_DEPTH(DEPTH), .ALPHA(8'h00)) dut (
        .aclk                 (aclk),
        .areset               (areset),
        .cfg_enable           (cfg_enable),
        .vid_valid            (vid_valid),
        .vid_data             (vid_data),
        .vid_sof              (vid_sof),
        .vid_eol              (vid_eol),
        .OUTPUT_STREAM_TVALID (tvalid),
        .OUTPUT_STREAM_TREADY (tready),
        .OUTPUT_STREAM_TDATA  (tdata),
        .OUTPUT_STREAM_TKEEP  (tkeep),
        .OUTPUT_STREAM_TSTRB  (tstrb),
        .OUTPUT_STREAM_TUSER  (tuser),
        .OUTPUT_STREAM_TLAST  (tlast),
        .OUTPUT_STREAM_TID    (tid),
        .OUTPUT_STREAM_TDEST  (tdest),
        .fifo_level           (fifo_level),
        .overflow             (overflow),
        .in_frame             (in_frame),
        .ovf_count            (ovf_count)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail < 40)
                $display("FAIL %s @%0t got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic compare_all();
        check("tvalid", 32'(tvalid), 32'(q.size() != 0));
        check("level", 32'(fifo_level), q.size());
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("in_frame", 32'(in_frame), 32'(mode == 1));
        check("ovf_count", 32'(ovf_count), m_cnt);
        if (q.size() != 0) begin
            check("tdata", tdata, {8'h00, q[0][23:0]});
            check("tuser", 32'(tuser), 32'(q[0][25]));
            check("tlast", 32'(tlast), 32'(q[0][24]));
        end
    endtask

    // mode: 0 waiting for sof, 1 active, 2 dropping.
    task automatic tick(input logic rst, input logic en, input logic v,
                        input logic s, input logic e, input logic [23:0] d,
                        input logic r);
        logic full, wr, ovf_n;
        @(negedge aclk);
        compare_all();
        areset = rst; cfg_enable = en; vid_valid = v;
        vid_sof = s; vid_eol = e; vid_data = d; tready = r;
        if (rst) begin
            q.delete(); mode = 0; m_ovf = 1'b0; m_cnt = 0;
        end else begin
            full  = (q.size() == DEPTH);
            wr    = 1'b0;
            ovf_n = 1'b0;
            if (!en) mode = 0;
            else if (mode == 1) begin
                if (v && full) begin ovf_n = 1'b1; mode = 2; end
                else if (v) wr = 1'b1;
            end else if (v && s && !full) begin
                wr = 1'b1; mode = 1;
            end
            if (q.size() != 0 && r) void'(q.pop_front());
            if (wr) q.push_back({s, e, d});
            m_ovf = ovf_n;
`ifdef ERROR_CNT_EN
            if (ovf_n && m_cnt < 65535) m_cnt++;
`endif
        end
    endtask

    initial begin
        tick(1, 0, 0, 0, 0, 24'h0, 0);
        tick(1, 0, 0, 0, 0, 24'h0, 0);
        @(negedge aclk);
        check("rst_tdata", tdata, 32'h0);
        check("rst_tkeep", 32'(tkeep), 32'hF);
        check("rst_tstrb", 32'(tstrb), 32'hF);
        check("rst_tid", 32'({tid, tdest}), 32'h0);
        check("rst_flags", 32'({tuser, tlast}), 32'h0);

        // Pixels before any sof are discarded.
        for (int i = 0; i < 5; i++) tick(0, 1, 1, 0, 0, 24'hA0 + 24'(i), 0);
        // Four-pixel line, sink ready.
        for (int i = 0; i < 4; i++)
            tick(0, 1, 1, i == 0, i == 3, 24'(i + 1), 1);
        for (int i = 0; i < 4; i++) tick(0, 1, 0, 0, 0, 24'h0, 1);

        // Overflow episodes with the sink stalled, then drain.
        for (int ep = 0; ep < 3; ep++) begin
            for (int i = 0; i < 20; i++)
                tick(0, 1, 1, i == 0, 0, 24'h100 * 24'(ep) + 24'(i), 0);
            @(negedge aclk);
            check("ovf_level16", 32'(fifo_level), 32'd16);
            check("ovf_in_frame0", 32'(in_frame), 32'd0);
            for (int i = 0; i < 18; i++) tick(0, 1, 1, 0, 0, 24'h5555, 1);
            check("drained", 32'(q.size()), 32'(fifo_level));
        end
        @(negedge aclk);
`ifdef ERROR_CNT_EN
        check("ovf_count3", 32'(ovf_count), 32'd3);
`else
        check("ovf_count0", 32'(ovf_count), 32'd0);
`endif

        // Alternating ready with continuous input.
        for (int i = 0; i < 40; i++)
            tick(0, 1, 1, i == 0, (i % 8) == 7, 24'($urandom), i[0]);
        // Disable mid-line, drain, re-enable.
        for (int i = 0; i < 20; i++) tick(0, 0, 1, 0, 0, 24'($urandom), 1);
        check("disabled_empty", 32'(fifo_level), 32'd0);
        for (int i = 0; i < 10; i++)
            tick(0, 1, 1, i == 3, 0, 24'($urandom), 1);

        // Random traffic with occasional reset.
        for (int i = 0; i < 4000; i++)
            tick(($urandom % 600) == 0, ($urandom % 20) != 0,
                 ($urandom % 10) < 7, ($urandom % 25) == 0,
                 ($urandom % 8) == 0, 24'($urandom),
                 ($urandom % 10) < 6);
        tick(0, 1, 0, 0, 0, 24'h0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
